// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seg7 scan controller
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] digit_t;
  typedef logic [2:0] seg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_next_digit.sv
// rtl/seg7_next_digit.sv - combinational round-robin finder for the next enabled digit
module seg7_next_digit
  import seg7_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] mask,
  input  digit_t                ptr,
  output digit_t                next_idx,
  output logic                  found,
  output logic                  wrapped
);

  // Walk candidates from farthest to nearest so the nearest enabled digit after
  // ptr wins; offset NUM_DIGITS lands back on ptr itself (single-digit case).
  always_comb begin
    next_idx = ptr;
    found    = 1'b0;
    wrapped  = 1'b0;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_DIGITS;
      if (mask[j]) begin
        next_idx = digit_t'(j);
        found    = 1'b1;
        wrapped  = (digit_t'(j) <= ptr);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 6-digit scan controller with blanking gap
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV     = 1000,
  parameter int GAP_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_data,
  input  logic       mask_wr,
  input  logic [5:0] mask_data,
  output logic [2:0] seg_idx,
  output logic [2:0] digit_idx,
  output logic       blank,
  output logic       frame_done
);

  localparam int MAXC = (DIV > GAP_CYC) ? DIV : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  digit_t                  ptr_n;
  seg_t                    seg_n;
  logic                    blank_n, fd_n;
  seg_t                    regs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   mask;

  digit_t                  find_ptr, nxt;
  logic                    found, wrapped;

  // From IDLE, searching after the last digit yields the lowest enabled digit.
  assign find_ptr = (state == IDLE) ? digit_t'(NUM_DIGITS - 1) : digit_idx;

  seg7_next_digit u_next (
    .mask     (mask),
    .ptr      (find_ptr),
    .next_idx (nxt),
    .found    (found),
    .wrapped  (wrapped)
  );

  // Register file and enable mask; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) regs[i] <= '0;
      mask <= '1;
    end else begin
      if (wr_en && (wr_addr < 3'(NUM_DIGITS))) regs[wr_addr] <= wr_data;
      if (mask_wr) mask <= mask_data;
    end
  end

  // Next-state and next-output logic; seg_idx only reloads on SHOW entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = digit_idx;
    seg_n   = seg_idx;
    fd_n    = 1'b0;
    if (!run) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state_n = SHOW;
            cnt_n   = '0;
            ptr_n   = nxt;
            seg_n   = regs[nxt];
          end
        end
        SHOW: begin
          if (cnt == DIV_LAST) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_n = '0;
            if (found) begin
              state_n = SHOW;
              ptr_n   = nxt;
              seg_n   = regs[nxt];
              fd_n    = wrapped;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    blank_n = (state_n != SHOW);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      seg_idx    <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= ptr_n;
      seg_idx    <= seg_n;
      blank      <= blank_n;
      frame_done <= fd_n;
    end
  end

endmodule
